// File: rtl/fp29i_to_fp16_pack_pkg.sv
// Shared FP datapath constants: FP29i operand geometry, FP16 field layout,
// special FP16 encodings and the bit positions of the packer status flags.
package fpalu_pkg;

    localparam int ML_MANSIZE = 22;
    localparam int ML_EXPSIZE = 6;
    localparam int ML_EXPBIAS = 31;

    localparam int FP16_EXPW  = 5;
    localparam int FP16_FRACW = 10;
    localparam int FP16_BIAS  = 15;

    localparam logic [15:0] FP16_INF  = 16'h7C00;
    localparam logic [15:0] FP16_MAXN = 16'h7BFF;

    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    // Everything the final packing stage needs once rounding has been decided
    typedef struct packed {
        logic                  sgn;
        logic                  zero;
        logic                  ovfPre;
        logic                  tiny;
        logic [FP16_EXPW-1:0]  exp5;
        logic [FP16_FRACW-1:0] frac;
        logic                  inc;
        logic                  inexact;
    } roundStage_t;

endpackage

// File: rtl/fp29i_to_fp16_pack_count_lead_zero.sv
// Leading-zero counter; an all-zero input reports W_IN.
module count_lead_zero #(
    parameter int W_IN  = 32,
    parameter int W_OUT = $clog2(W_IN + 1)
) (
    input  logic [W_IN-1:0]  i_data,
    output logic [W_OUT-1:0] o_count
);

    // The highest set bit is visited last, so it decides the count
    always_comb begin
        o_count = W_OUT'(W_IN);
        for (int i = 0; i < W_IN; i++) begin
            if (i_data[i]) begin
                o_count = W_OUT'(W_IN - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp29i_to_fp16_pack.sv
// FP29i -> IEEE FP16 output packer with round-to-nearest-even.
// Stage 1 normalises the mantissa, stage 2 picks the normal/subnormal
// alignment and the rounding increment, stage 3 applies it and handles
// overflow and zero. A single advance signal stalls all stages together.
module fp29i_to_fp16_pack
    import fpalu_pkg::*;
#(
    parameter int IN_EXPBIAS  = ML_EXPBIAS,
    parameter int OUT_EXPBIAS = FP16_BIAS,
    parameter bit SAT_ON_OVF  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sgn,
    input  logic [ML_EXPSIZE-1:0] in_exp,
    input  logic [ML_MANSIZE-1:0] in_man_dn,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_fp16,
    output logic [2:0]            out_flags
);

    localparam logic signed [7:0] BIAS_DIFF = 8'(IN_EXPBIAS - OUT_EXPBIAS);

    logic                   w_adv;
    logic [5:0]             w_lzd;
    logic [21:0]            w_manNorm;
    logic signed [7:0]      w_expNorm;

    logic                   r_s1Valid;
    logic                   r_s1Sgn;
    logic                   r_s1Zero;
    logic [21:0]            r_s1Man;
    logic signed [7:0]      r_s1Exp;

    logic signed [7:0]      w_e16;
    logic signed [7:0]      w_shRaw;
    logic                   w_sub;
    logic [3:0]             w_sh;
    logic [32:0]            w_ext;
    logic                   w_guard;
    logic                   w_sticky;
    roundStage_t            w_s2Next;

    logic                   r_s2Valid;
    roundStage_t            r_s2;

    logic [14:0]            w_packed;
    logic                   w_ovf;
    logic [15:0]            w_res;
    logic [2:0]             w_flags;

    logic                   r_outValid;
    logic [15:0]            r_outFp16;
    logic [2:0]             r_outFlags;

    assign w_adv     = ~r_outValid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_outValid;
    assign out_fp16  = r_outFp16;
    assign out_flags = r_outFlags;

    count_lead_zero #(
        .W_IN (32)
    ) u_clz (
        .i_data  ({in_man_dn, 10'b0}),
        .o_count (w_lzd)
    );

    assign w_manNorm = in_man_dn << w_lzd;
    assign w_expNorm = $signed({2'b00, in_exp}) - $signed({2'b00, w_lzd});

    // Stage 1: capture the normalised operand so bit 21 is the integer bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1Sgn   <= 1'b0;
            r_s1Zero  <= 1'b0;
            r_s1Man   <= '0;
            r_s1Exp   <= '0;
        end else if (w_adv) begin
            r_s1Valid <= in_valid;
            r_s1Sgn   <= in_sgn;
            r_s1Zero  <= (in_man_dn == '0);
            r_s1Man   <= w_manNorm;
            r_s1Exp   <= w_expNorm;
        end
    end

    // Stage 2 logic: rebias, denormalise tiny values, derive guard/sticky and the RNE increment
    always_comb begin
        w_e16    = r_s1Exp - BIAS_DIFF;
        w_sub    = (w_e16 <= 8'sd0);
        w_shRaw  = 8'sd1 - w_e16;
        w_sh     = 4'd0;
        if (w_sub) begin
            w_sh = (w_shRaw > 8'sd12) ? 4'd12 : w_shRaw[3:0];
        end
        w_ext    = 33'({r_s1Man, 12'b0} >> w_sh);
        w_guard  = w_ext[22];
        w_sticky = |w_ext[21:0];

        w_s2Next         = '0;
        w_s2Next.sgn     = r_s1Sgn;
        w_s2Next.zero    = r_s1Zero;
        w_s2Next.ovfPre  = (w_e16 >= 8'sd31);
        w_s2Next.tiny    = w_sub;
        w_s2Next.exp5    = w_sub ? 5'd0 : w_e16[4:0];
        w_s2Next.frac    = w_ext[32:23];
        w_s2Next.inc     = w_guard & (w_sticky | w_ext[23]);
        w_s2Next.inexact = w_guard | w_sticky;
    end

    // Stage 2: hold the rounding decision
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2Valid <= 1'b0;
            r_s2      <= '0;
        end else if (w_adv) begin
            r_s2Valid <= r_s1Valid;
            r_s2      <= w_s2Next;
        end
    end

    // Stage 3 logic: one adder applies the increment, letting carries ripple into the exponent
    always_comb begin
        w_packed = {r_s2.exp5, r_s2.frac} + 15'(r_s2.inc);
        w_ovf    = r_s2.ovfPre | (w_packed[14:10] == 5'd31);
        w_flags  = '0;
        w_res    = {r_s2.sgn, w_packed};
        if (r_s2.zero) begin
            w_res = {r_s2.sgn, 15'b0};
        end else if (w_ovf) begin
            w_res = {r_s2.sgn, SAT_ON_OVF ? FP16_MAXN[14:0] : FP16_INF[14:0]};
            w_flags[FLAG_OVF] = 1'b1;
            w_flags[FLAG_INX] = 1'b1;
        end else begin
            w_flags[FLAG_UNF] = r_s2.tiny & r_s2.inexact;
            w_flags[FLAG_INX] = r_s2.inexact;
        end
    end

    // Output register: result is held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outFp16  <= '0;
            r_outFlags <= '0;
        end else if (w_adv) begin
            r_outValid <= r_s2Valid;
            r_outFp16  <= w_res;
            r_outFlags <= w_flags;
        end
    end

endmodule

// File: tb/tb_fp29i_to_fp16_pack.sv
// Self-checking bench: two packers (infinity and saturating overflow) share stimulus.
module tb_fp29i_to_fp16_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_sgn;
    logic [5:0]  in_exp;
    logic [21:0] in_man_dn;
    logic        out_ready;
    logic        in_ready, in_ready_s;
    logic        out_valid, out_valid_s;
    logic [15:0] out_fp16, out_fp16_s;
    logic [2:0]  out_flags, out_flags_s;

    int checks = 0;
    int failures = 0;

    logic [18:0] expQ[$];
    logic [18:0] expSQ[$];

    typedef struct {
        logic        s;
        logic [5:0]  e;
        logic [21:0] m;
        logic [15:0] r0;
        logic [2:0]  f0;
        logic [15:0] r1;
        logic [2:0]  f1;
    } vec_t;

    vec_t dirVecs[14];

    always #5 clk = ~clk;

    fp29i_to_fp16_pack #(.SAT_ON_OVF(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sgn(in_sgn), .in_exp(in_exp), .in_man_dn(in_man_dn),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_fp16(out_fp16), .out_flags(out_flags)
    );

    fp29i_to_fp16_pack #(.SAT_ON_OVF(1'b1)) dutSat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_sgn(in_sgn), .in_exp(in_exp), .in_man_dn(in_man_dn),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_fp16(out_fp16_s), .out_flags(out_flags_s)
    );

    // Reference: value = m * 2^(e-52); quantise to the FP16 ulp with exact integer RNE
    function automatic logic [18:0] refPack(input logic s, input logic [5:0] e,
                                            input logic [21:0] m, input bit sat);
        int p, bigE, ulp, sh;
        longint unsigned n, rem, half, mag;
        bit tiny, inexact;
        if (m == 22'd0) return {3'b000, s, 15'b0};
        p = 0;
        for (int i = 0; i < 22; i++) if (m[i]) p = i;
        bigE = int'(e) - 31 + p - 21;
        tiny = (bigE < -14);
        ulp  = tiny ? -24 : bigE - 10;
        sh   = int'(e) - 52 - ulp;
        if (sh >= 0) begin
            n = longint'(m) << sh;
            rem = 0;
            half = 1;
        end else begin
            n = longint'(m) >> (-sh);
            rem = longint'(m) & ((64'd1 << (-sh)) - 64'd1);
            half = 64'd1 << (-sh - 1);
        end
        inexact = (rem != 0);
        if (rem > half || (rem == half && n[0])) n = n + 1;
        mag = tiny ? n : ((longint'(bigE + 14)) << 10) + n;
        if (mag >= 64'h7C00)
            return {3'b101, s, sat ? 15'h7BFF : 15'h7C00};
        return {1'b0, tiny & inexact, inexact, s, mag[14:0]};
    endfunction

    task automatic randomOperand();
        logic [21:0] one = 22'h1;
        int w;
        w = $urandom_range(0, 22);
        in_sgn    = 1'($urandom);
        in_exp    = 6'($urandom_range(0, 63));
        in_man_dn = 22'($urandom) & ((one << w) - 22'd1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_sgn = 1'b1; in_exp = 6'h3F;
        in_man_dn = 22'h3FFFFF; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_fp16 !== 16'h0) begin failures++; $display("[TB] FAIL reset_out_fp16: got %h expected 0000", out_fp16); end
        checks++; if (out_flags !== 3'b0) begin failures++; $display("[TB] FAIL reset_out_flags: got %b expected 000", out_flags); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid_s !== 1'b0) begin failures++; $display("[TB] FAIL reset_sat_out_valid: got %b expected 0", out_valid_s); end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        bit expV;
        in_sgn = 1'b0; in_exp = 6'd31; in_man_dn = 22'h200000;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL latency_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            expV = (c == 3);
            checks++;
            if (out_valid !== expV) begin
                failures++;
                $display("[TB] FAIL latency_valid_edge%0d: got %b expected %b", c, out_valid, expV);
            end
            if (c < 3) begin @(posedge clk); #1; end
        end
        checks++; if (out_fp16 !== 16'h3C00) begin failures++; $display("[TB] FAIL latency_one: got %h expected 3c00", out_fp16); end
        checks++; if (out_flags !== 3'b000) begin failures++; $display("[TB] FAIL latency_flags: got %b expected 000", out_flags); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL latency_no_dup: got %b expected 0", out_valid); end
    endtask

    task automatic test_directed();
        int waitCnt;
        dirVecs[0]  = '{1'b0, 6'd31, 22'h200000, 16'h3C00, 3'b000, 16'h3C00, 3'b000};
        dirVecs[1]  = '{1'b0, 6'd31, 22'h200400, 16'h3C00, 3'b001, 16'h3C00, 3'b001};
        dirVecs[2]  = '{1'b0, 6'd31, 22'h200C00, 16'h3C02, 3'b001, 16'h3C02, 3'b001};
        dirVecs[3]  = '{1'b0, 6'd31, 22'h3FFC00, 16'h4000, 3'b001, 16'h4000, 3'b001};
        dirVecs[4]  = '{1'b0, 6'd47, 22'h200000, 16'h7C00, 3'b101, 16'h7BFF, 3'b101};
        dirVecs[5]  = '{1'b1, 6'd47, 22'h200000, 16'hFC00, 3'b101, 16'hFBFF, 3'b101};
        dirVecs[6]  = '{1'b0, 6'd16, 22'h200000, 16'h0200, 3'b000, 16'h0200, 3'b000};
        dirVecs[7]  = '{1'b0, 6'd6,  22'h200000, 16'h0000, 3'b011, 16'h0000, 3'b011};
        dirVecs[8]  = '{1'b1, 6'd20, 22'h000000, 16'h8000, 3'b000, 16'h8000, 3'b000};
        dirVecs[9]  = '{1'b0, 6'd52, 22'h000001, 16'h3C00, 3'b000, 16'h3C00, 3'b000};
        dirVecs[10] = '{1'b0, 6'd46, 22'h3FF800, 16'h7BFF, 3'b000, 16'h7BFF, 3'b000};
        dirVecs[11] = '{1'b0, 6'd46, 22'h3FFC00, 16'h7C00, 3'b101, 16'h7BFF, 3'b101};
        dirVecs[12] = '{1'b0, 6'd16, 22'h3FFFFF, 16'h0400, 3'b011, 16'h0400, 3'b011};
        dirVecs[13] = '{1'b1, 6'd0,  22'h000000, 16'h8000, 3'b000, 16'h8000, 3'b000};
        out_ready = 1'b1;
        for (int v = 0; v < 14; v++) begin
            in_sgn = dirVecs[v].s; in_exp = dirVecs[v].e; in_man_dn = dirVecs[v].m;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            waitCnt = 0;
            while (out_valid !== 1'b1 && waitCnt < 10) begin
                @(posedge clk); #1;
                waitCnt++;
            end
            checks++;
            if (out_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL directed%0d_timeout: got out_valid %b expected 1", v, out_valid);
            end else begin
                if (out_fp16 !== dirVecs[v].r0) begin failures++; $display("[TB] FAIL directed%0d_fp16: got %h expected %h", v, out_fp16, dirVecs[v].r0); end
                checks++;
                if (out_flags !== dirVecs[v].f0) begin failures++; $display("[TB] FAIL directed%0d_flags: got %b expected %b", v, out_flags, dirVecs[v].f0); end
                checks++;
                if (out_fp16_s !== dirVecs[v].r1) begin failures++; $display("[TB] FAIL directed%0d_sat_fp16: got %h expected %h", v, out_fp16_s, dirVecs[v].r1); end
                checks++;
                if (out_flags_s !== dirVecs[v].f1) begin failures++; $display("[TB] FAIL directed%0d_sat_flags: got %b expected %b", v, out_flags_s, dirVecs[v].f1); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random(input int nTx);
        int sent, got, cyc;
        bit pending;
        logic [18:0] e0, e1;
        sent = 0; got = 0; cyc = 0; pending = 1'b0;
        expQ.delete(); expSQ.delete();
        while ((sent < nTx || got < sent) && cyc < 20 * nTx + 100) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if (!pending && sent < nTx && $urandom_range(0, 9) < 8) begin
                randomOperand();
                pending = 1'b1;
            end
            in_valid = pending;
            #1;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL random_unexpected: got %h expected no output", out_fp16);
                end else begin
                    e0 = expQ.pop_front(); e1 = expSQ.pop_front(); got++;
                    checks++; if (out_fp16 !== e0[15:0]) begin failures++; $display("[TB] FAIL random_fp16 #%0d: got %h expected %h", got, out_fp16, e0[15:0]); end
                    checks++; if (out_flags !== e0[18:16]) begin failures++; $display("[TB] FAIL random_flags #%0d: got %b expected %b", got, out_flags, e0[18:16]); end
                    checks++; if (out_fp16_s !== e1[15:0]) begin failures++; $display("[TB] FAIL random_sat_fp16 #%0d: got %h expected %h", got, out_fp16_s, e1[15:0]); end
                    checks++; if (out_flags_s !== e1[18:16]) begin failures++; $display("[TB] FAIL random_sat_flags #%0d: got %b expected %b", got, out_flags_s, e1[18:16]); end
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back(refPack(in_sgn, in_exp, in_man_dn, 1'b0));
                expSQ.push_back(refPack(in_sgn, in_exp, in_man_dn, 1'b1));
                sent++;
                pending = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != nTx || sent != nTx) begin
            failures++;
            $display("[TB] FAIL random_count: got %0d results of %0d sent, expected %0d", got, sent, nTx);
        end
    endtask

    task automatic test_backpressure();
        logic        sArr[6];
        logic [5:0]  eArr[6];
        logic [21:0] mArr[6];
        logic [15:0] held;
        logic [2:0]  heldF;
        logic [18:0] e0;
        bit haveHeld;
        int idx, got, cyc;
        for (int i = 0; i < 6; i++) begin
            randomOperand();
            sArr[i] = in_sgn; eArr[i] = in_exp; mArr[i] = in_man_dn;
        end
        expQ.delete();
        idx = 0; haveHeld = 1'b0; held = '0; heldF = '0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 6);
            if (idx < 6) begin in_sgn = sArr[idx]; in_exp = eArr[idx]; in_man_dn = mArr[idx]; end
            #1;
            if (out_valid) begin
                if (!haveHeld) begin
                    held = out_fp16; heldF = out_flags; haveHeld = 1'b1;
                end else begin
                    checks++;
                    if (out_fp16 !== held || out_flags !== heldF) begin
                        failures++;
                        $display("[TB] FAIL stall_hold: got %h/%b expected %h/%b", out_fp16, out_flags, held, heldF);
                    end
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back(refPack(in_sgn, in_exp, in_man_dn, 1'b0));
                idx++;
            end
            @(posedge clk); #1;
        end
        checks++; if (idx !== 3) begin failures++; $display("[TB] FAIL stall_accepted: got %0d expected 3", idx); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_out_valid: got %b expected 1", out_valid); end
        out_ready = 1'b1;
        got = 0; cyc = 0;
        while ((idx < 6 || got < idx) && cyc < 50) begin
            in_valid = (idx < 6);
            if (idx < 6) begin in_sgn = sArr[idx]; in_exp = eArr[idx]; in_man_dn = mArr[idx]; end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL drain_unexpected: got %h expected no output", out_fp16);
                end else begin
                    e0 = expQ.pop_front(); got++;
                    if (out_fp16 !== e0[15:0] || out_flags !== e0[18:16]) begin
                        failures++;
                        $display("[TB] FAIL drain_order #%0d: got %h/%b expected %h/%b", got, out_fp16, out_flags, e0[15:0], e0[18:16]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back(refPack(in_sgn, in_exp, in_man_dn, 1'b0));
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (got !== 6) begin failures++; $display("[TB] FAIL drain_count: got %0d expected 6", got); end
    endtask

    task automatic test_reset_midstream();
        int waitCnt;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            randomOperand();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_fp16 !== 16'h0) begin failures++; $display("[TB] FAIL midreset_out_fp16: got %h expected 0000", out_fp16); end
        checks++; if (out_flags !== 3'b0) begin failures++; $display("[TB] FAIL midreset_out_flags: got %b expected 000", out_flags); end
        checks++; if (out_valid_s !== 1'b0) begin failures++; $display("[TB] FAIL midreset_sat_valid: got %b expected 0", out_valid_s); end
        rst_n = 1'b1; in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_stale%0d: got %b expected 0", c, out_valid); end
        end
        in_sgn = 1'b1; in_exp = 6'd31; in_man_dn = 22'h200C00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waitCnt = 0;
        while (out_valid !== 1'b1 && waitCnt < 10) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_fp16 !== 16'hBC02 || out_flags !== 3'b001) begin
            failures++;
            $display("[TB] FAIL midreset_recover: got %b/%h/%b expected 1/bc02/001", out_valid, out_fp16, out_flags);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_random(300);
        test_backpressure();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
